// File: rtl/bcd_updown_chain_pkg.sv
// Shared constants and types for the multi-digit BCD up/down counter.
package bcd_updown_chain_pkg;

    localparam int BCD_BIT_WIDTH = 4;

    typedef logic [BCD_BIT_WIDTH-1:0] bcd_t;

    localparam bcd_t BCD_ZERO  = 4'd0;
    localparam bcd_t BCD_NINE  = 4'd9;
    localparam bcd_t INCREMENT = 4'd1;
    localparam bcd_t DECREMENT = 4'd1;

    localparam logic ENABLED   = 1'b1;
    localparam logic DISABLED  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

endpackage

// File: rtl/bcd_updown_chain_digit.sv
// One BCD digit with its own upper limit. It steps when told to and reports
// whether it currently sits on the boundary for the selected direction, so the
// parent can decide whether the next digit steps too.
module bcd_updown_digit
    import bcd_updown_chain_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       dir,
    input  logic       load,
    input  bcd_t       def,
    input  bcd_t       limit,
    output bcd_t       value,
    output logic       at_boundary
);

    bcd_t next_value;

    // Next value for a single step; >= on the up side lets an out-of-range
    // digit fall back to zero, while the down side just decrements it.
    always_comb begin
        next_value  = value;
        at_boundary = 1'b0;
        if (dir == DIR_UP) begin
            at_boundary = (value >= limit);
            next_value  = (value >= limit) ? BCD_ZERO : value + INCREMENT;
        end else begin
            at_boundary = (value == BCD_ZERO);
            next_value  = (value == BCD_ZERO) ? limit : value - DECREMENT;
        end
    end

    // Digit register: reset and load both take the default value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= def;
        end else if (load) begin
            value <= def;
        end else if (step) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/bcd_updown_chain.sv
// Multi-digit BCD up/down counter with per-digit limits, wrap or saturate at
// the range ends, carry/borrow out and a registered terminal-count pulse.
module bcd_updown_chain
    import bcd_updown_chain_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              dir,
    input  logic                              load_default,
    input  logic [DIGITS*BCD_BIT_WIDTH-1:0]   def_value,
    input  logic [DIGITS*BCD_BIT_WIDTH-1:0]   limit_value,
    output logic [DIGITS*BCD_BIT_WIDTH-1:0]   value,
    output logic                              carry,
    output logic                              borrow,
    output logic                              tc,
    output logic                              overflowed
);

    logic [DIGITS-1:0] at_boundary;
    logic [DIGITS-1:0] chain_ok;
    logic              all_boundary;
    logic              acc;
    logic              hold;

    // Prefix AND of the digit boundaries: digit i may step only when every
    // lower digit is at its boundary; the full product is the range end.
    always_comb begin
        acc      = 1'b1;
        chain_ok = '0;
        for (int i = 0; i < DIGITS; i++) begin
            chain_ok[i] = acc;
            acc         = acc & at_boundary[i];
        end
        all_boundary = acc;
    end

    assign carry  = en & (dir == DIR_UP)   & all_boundary;
    assign borrow = en & (dir == DIR_DOWN) & all_boundary;

    // In saturate mode a step that would wrap the whole counter is dropped.
    assign hold = (WRAP == 0) & (carry | borrow);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_updown_digit u_digit (
                .clk         (clk),
                .rst_n       (rst_n),
                .step        (en & chain_ok[g] & ~hold),
                .dir         (dir),
                .load        (load_default),
                .def         (def_value[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
                .limit       (limit_value[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
                .value       (value[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
                .at_boundary (at_boundary[g])
            );
        end
    endgenerate

    // Terminal count pulse, one cycle after a carry/borrow step; a load
    // in the same cycle suppresses it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tc <= 1'b0;
        end else begin
            tc <= (carry | borrow) & ~load_default;
        end
    end

    // Sticky overflow flag; a load clears it even if a carry happens too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflowed <= 1'b0;
        end else if (load_default) begin
            overflowed <= 1'b0;
        end else if (carry | borrow) begin
            overflowed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_updown_chain.sv
// Directed bench for bcd_updown_chain: a wrapping and a saturating two-digit
// instance share the same stimulus.
module tb_bcd_updown_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load_default;
    logic [7:0] def_value;
    logic [7:0] limit_value;

    logic [7:0] value_w, value_s;
    logic       carry_w, borrow_w, tc_w, ovf_w;
    logic       carry_s, borrow_s, tc_s, ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_updown_chain #(.DIGITS(2), .WRAP(1)) u_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .dir          (dir),
        .load_default (load_default),
        .def_value    (def_value),
        .limit_value  (limit_value),
        .value        (value_w),
        .carry        (carry_w),
        .borrow       (borrow_w),
        .tc           (tc_w),
        .overflowed   (ovf_w)
    );

    bcd_updown_chain #(.DIGITS(2), .WRAP(0)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .dir          (dir),
        .load_default (load_default),
        .def_value    (def_value),
        .limit_value  (limit_value),
        .value        (value_s),
        .carry        (carry_s),
        .borrow       (borrow_s),
        .tc           (tc_s),
        .overflowed   (ovf_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with en high
        rst_n        = 1'b0;
        en           = 1'b1;
        dir          = 1'b1;
        load_default = 1'b0;
        def_value    = 8'h12;
        limit_value  = 8'h59;
        tick();
        check("rst_value", value_w, 8'h12);
        check("rst_tc", tc_w, 0);
        check("rst_ovf", ovf_w, 0);
        tick();
        check("rst_value_hold", value_w, 8'h12);
        rst_n = 1'b1;
        en    = 1'b0;
        #1;
        check("carry_en0", carry_w, 0);

        // Seconds counter 57 -> 58 -> 59 -> 00
        def_value    = 8'h57;
        load_default = 1'b1;
        tick();
        load_default = 1'b0;
        check("sec_load", value_w, 8'h57);
        en  = 1'b1;
        dir = 1'b1;
        #1;
        check("sec_carry_57", carry_w, 0);
        tick();
        check("sec_58", value_w, 8'h58);
        tick();
        check("sec_59", value_w, 8'h59);
        check("sec_tc_59", tc_w, 0);
        check("sec_carry_59", carry_w, 1);
        tick();
        check("sec_00", value_w, 8'h00);
        check("sec_tc", tc_w, 1);
        check("sec_ovf", ovf_w, 1);
        en = 1'b0;
        tick();
        check("sec_tc_drop", tc_w, 0);
        check("sec_hold", value_w, 8'h00);

        // Countdown 01 -> 00 -> 99
        limit_value  = 8'h99;
        def_value    = 8'h01;
        load_default = 1'b1;
        tick();
        load_default = 1'b0;
        check("dn_load", value_w, 8'h01);
        check("dn_ovf_clr", ovf_w, 0);
        en  = 1'b1;
        dir = 1'b0;
        #1;
        check("dn_borrow_01", borrow_w, 0);
        tick();
        check("dn_00", value_w, 8'h00);
        check("dn_borrow_00", borrow_w, 1);
        check("dn_carry_00", carry_w, 0);
        tick();
        check("dn_99", value_w, 8'h99);
        check("dn_tc", tc_w, 1);
        en = 1'b0;

        // Saturate at 23 going up
        limit_value  = 8'h23;
        def_value    = 8'h23;
        load_default = 1'b1;
        tick();
        load_default = 1'b0;
        en  = 1'b1;
        dir = 1'b1;
        #1;
        check("sat_carry", carry_s, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_value", value_s, 8'h23);
            check("sat_tc", tc_s, 1);
            check("sat_carry_hold", carry_s, 1);
        end
        check("sat_ovf", ovf_s, 1);

        // Load wins over a carrying step
        def_value    = 8'h05;
        load_default = 1'b1;
        tick();
        check("ld_value", value_s, 8'h05);
        check("ld_ovf", ovf_s, 0);
        check("ld_tc", tc_s, 0);
        en        = 1'b0;
        def_value = 8'h11;
        tick();
        load_default = 1'b0;
        check("ld_en0", value_s, 8'h11);

        // Out-of-range digit 7 with limit 5
        limit_value  = 8'h95;
        def_value    = 8'h17;
        load_default = 1'b1;
        tick();
        load_default = 1'b0;
        en  = 1'b1;
        dir = 1'b1;
        tick();
        check("oor_up", value_w, 8'h20);
        en           = 1'b0;
        load_default = 1'b1;
        tick();
        load_default = 1'b0;
        en  = 1'b1;
        dir = 1'b0;
        tick();
        check("oor_dn", value_w, 8'h16);
        en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
